// File: rtl/quickq_pkg.sv
// quickq_pkg: shared state type, width formulas and the build-selected ordering test (QQ_MAX_QUEUE_EN selects max-queue).
package quickq_pkg;
  typedef enum logic {IDLE, INSERT} state_t;
  localparam int QQ_KEY_MAX = 64;
  function automatic int qq_count_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int qq_idx_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  // True when the stored key a must move toward the tail ahead of new key b; equality shifts to keep ties stable.
  function automatic logic qq_shift(input logic [QQ_KEY_MAX-1:0] a, input logic [QQ_KEY_MAX-1:0] b);
`ifdef QQ_MAX_QUEUE_EN
    return a >= b;
`else
    return a <= b;
`endif
  endfunction
endpackage

// File: rtl/quickq_sorted_mem.sv
// quickq_sorted_mem: DEPTH x W key array, one synchronous write port, combinational scan and tail read ports.
module quickq_sorted_mem #(
  parameter int W = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] scan_addr,
  input  logic [AW-1:0] tail_addr,
  output logic [W-1:0]  scan_data,
  output logic [W-1:0]  tail_data
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign scan_data = mem[scan_addr];
  assign tail_data = mem[tail_addr];
endmodule

// File: rtl/quickq_sorted_queue.sv
// quickq_sorted_queue: sorted-array priority queue, single-cycle dequeue of the tail, shift-based insertion.
// Min-queue by default; define QQ_MAX_QUEUE_EN for a max-queue.
module quickq_sorted_queue
  import quickq_pkg::*;
#(
  parameter int W = 32,
  parameter int DEPTH = 8,
  localparam int CW = qq_count_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_valid,
  input  logic [W-1:0]  enq_data,
  output logic          enq_ready,
  input  logic          deq_ready,
  output logic          deq_valid,
  output logic [W-1:0]  deq_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          busy
);
  localparam int IW = qq_idx_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_nx;
  logic signed [IW-1:0] idx;
  logic [W-1:0] ins_key, scan_data, tail_data, wdata;
  logic [CW-1:0] count_post;
  logic [AW-1:0] scan_addr, tail_addr, waddr;
  logic enq_fire, deq_fire, idx_neg, shift;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign enq_fire = enq_valid && enq_ready;
  assign deq_fire = deq_valid && deq_ready;
  assign count_post = count - CW'(deq_fire);
  assign idx_neg = idx[IW-1];
  assign shift = !idx_neg && qq_shift(QQ_KEY_MAX'(scan_data), QQ_KEY_MAX'(ins_key));
  // Address guards keep both read ports in range when idx = -1 or the queue is empty.
  assign scan_addr = idx_neg ? '0 : idx[AW-1:0];
  assign tail_addr = empty ? '0 : AW'(count - CW'(1));
  assign waddr = AW'(idx + IW'(1));
  assign wdata = shift ? scan_data : ins_key;
  assign deq_data = deq_valid ? tail_data : '0;
  quickq_sorted_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(state == INSERT),
    .waddr(waddr),
    .wdata(wdata),
    .scan_addr(scan_addr),
    .tail_addr(tail_addr),
    .scan_data(scan_data),
    .tail_data(tail_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (enq_fire ? INSERT : IDLE) : (shift ? INSERT : IDLE);
  end
  always_comb begin
    enq_ready = state == IDLE && !full;
    deq_valid = state == IDLE && !empty;
    busy = state == INSERT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      idx <= '0;
      ins_key <= '0;
    end else if (state == IDLE) begin
      count <= count_post;
      if (enq_fire) begin
        ins_key <= enq_data;
        idx <= IW'(count_post) - IW'(1);
      end
    end else if (shift) idx <= idx - IW'(1);
    else count <= count + CW'(1);
endmodule

// File: tb/tb_quickq_sorted_queue.sv
// tb_quickq_sorted_queue: directed self-checking bench for the default min-queue build, W=32, DEPTH=8.
module tb_quickq_sorted_queue;
  logic clk = 0, rst = 1, enq_valid = 0, deq_ready = 0;
  logic [31:0] enq_data = 0;
  logic enq_ready, deq_valid, full, empty, busy;
  logic [31:0] deq_data;
  logic [3:0] count;
  int checks = 0, errors = 0;

  quickq_sorted_queue #(.W(32), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_data(deq_data), .count(count),
    .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    enq_valid = 0;
    deq_ready = 0;
    enq_data = 0;
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  task automatic enq(input logic [31:0] k, output int cyc);
    int w;
    w = 0;
    enq_data = k;
    enq_valid = 1;
    while (!enq_ready && w < 50) begin tick(); w++; end
    if (w >= 50) begin checks++; errors++; $display("FAIL enq_wait: enq_ready stuck at %b, need 1", enq_ready); end
    tick();
    enq_valid = 0;
    cyc = 0;
    while (busy && cyc < 100) begin tick(); cyc++; end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({count, empty, full, busy, enq_ready, deq_valid, deq_data} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset: count=%0d empty=%b full=%b busy=%b enq_ready=%b deq_valid=%b deq_data=%0d, need 0 1 0 0 1 0 0",
               count, empty, full, busy, enq_ready, deq_valid, deq_data);
    end
  endtask

  task automatic test_basic();
    int c;
    int exp_c [3] = '{1, 1, 3};
    logic [31:0] keys [3] = '{5, 2, 9};
    for (int i = 0; i < 3; i++) begin
      enq(keys[i], c);
      checks++;
      if (c !== exp_c[i]) begin errors++; $display("FAIL insert_len[%0d]: got %0d cycles, need %0d", i, c, exp_c[i]); end
    end
    @(negedge clk);
    checks++;
    if (count !== 4'd3 || deq_data !== 32'd2 || !deq_valid) begin
      errors++;
      $display("FAIL basic_state: count=%0d deq_data=%0d deq_valid=%b, need 3 2 1", count, deq_data, deq_valid);
    end
  endtask

  task automatic test_drain();
    logic [31:0] exp [3] = '{2, 5, 9};
    @(posedge clk);
    #1;
    deq_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (deq_data !== exp[i] || !deq_valid) begin
        errors++;
        $display("FAIL drain[%0d]: deq_data=%0d deq_valid=%b, need %0d 1", i, deq_data, deq_valid, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (!empty || deq_valid || deq_data !== 32'd0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b deq_valid=%b deq_data=%0d, need 1 0 0", empty, deq_valid, deq_data);
    end
    deq_ready = 0;
  endtask

  task automatic test_full();
    int c, w;
    do_reset();
    for (int k = 1; k <= 8; k++) enq(32'(k), c);
    @(negedge clk);
    checks++;
    if (!full || count !== 4'd8 || deq_data !== 32'd1) begin
      errors++;
      $display("FAIL full_state: full=%b count=%0d deq_data=%0d, need 1 8 1", full, count, deq_data);
    end
    @(posedge clk);
    #1;
    enq_data = 0;
    enq_valid = 1;
    @(negedge clk);
    checks++;
    if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_block: enq_ready=%b, need 0", enq_ready); end
    deq_ready = 1;
    tick();
    deq_ready = 0;
    checks++;
    if (count !== 4'd7 || busy || enq_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_after_deq: count=%0d busy=%b enq_ready=%b, need 7 0 1", count, busy, enq_ready);
    end
    tick();
    enq_valid = 0;
    w = 0;
    while (busy && w < 100) begin tick(); w++; end
    @(negedge clk);
    checks++;
    if (deq_data !== 32'd0 || count !== 4'd8 || w !== 1) begin
      errors++;
      $display("FAIL full_retry: deq_data=%0d count=%0d insert_cycles=%0d, need 0 8 1", deq_data, count, w);
    end
  endtask

  task automatic test_tie();
    int c;
    do_reset();
    enq(7, c);
    enq(7, c);
    // B must shift the older A toward the tail so A leaves first: two INSERT cycles.
    checks++;
    if (c !== 2) begin errors++; $display("FAIL tie_order: B insert took %0d cycles, need 2", c); end
    enq(3, c);
    deq_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (deq_data !== (i == 0 ? 32'd3 : 32'd7)) begin
        errors++;
        $display("FAIL tie_drain[%0d]: deq_data=%0d, need %0d", i, deq_data, i == 0 ? 3 : 7);
      end
    end
    @(posedge clk);
    #1;
    deq_ready = 0;
  endtask

  task automatic test_back_to_back();
    int c;
    do_reset();
    enq(4, c);
    enq_data = 3;
    enq_valid = 1;
    deq_ready = 1;
    @(negedge clk);
    checks++;
    if (deq_data !== 32'd4 || !deq_valid || !enq_ready) begin
      errors++;
      $display("FAIL simul_pre: deq_data=%0d deq_valid=%b enq_ready=%b, need 4 1 1", deq_data, deq_valid, enq_ready);
    end
    tick();
    enq_valid = 0;
    deq_ready = 0;
    checks++;
    if (!busy || count !== 4'd0) begin errors++; $display("FAIL simul_mid: busy=%b count=%0d, need 1 0", busy, count); end
    tick();
    checks++;
    if (busy || count !== 4'd1 || deq_data !== 32'd3) begin
      errors++;
      $display("FAIL simul_post: busy=%b count=%0d deq_data=%0d, need 0 1 3", busy, count, deq_data);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    do_reset();
    for (int k = 1; k <= 7; k++) enq(32'(k), c);
    enq_data = 100;
    enq_valid = 1;
    tick();
    enq_valid = 0;
    tick();
    tick();
    checks++;
    if (!busy) begin errors++; $display("FAIL mid_busy: busy=%b, need 1", busy); end
    #2;
    rst = 1;
    #1;
    checks++;
    if (!empty || count !== 4'd0 || busy) begin
      errors++;
      $display("FAIL mid_reset: empty=%b count=%0d busy=%b, need 1 0 0", empty, count, busy);
    end
    @(negedge clk);
    rst = 0;
    tick();
    enq(6, c);
    @(negedge clk);
    checks++;
    if (deq_data !== 32'd6 || count !== 4'd1 || c !== 1) begin
      errors++;
      $display("FAIL mid_after: deq_data=%0d count=%0d insert_cycles=%0d, need 6 1 1", deq_data, count, c);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drain();
    test_full();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
